// File: rtl/exec_unit_if.sv
// Operand/opcode request and write-back bundle between the issue logic and exec_unit.
// The master side issues operations; the slave side (exec_unit) returns write-backs.
interface exec_unit_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [1:0]   dst;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   wb_sel;
  logic [N-1:0] wb_data;
  logic         busy;

  modport master (
    output in_valid, op, dst, a, b,
    input  in_ready, wb_sel, wb_data, busy
  );

  modport slave (
    input  in_valid, op, dst, a, b,
    output in_ready, wb_sel, wb_data, busy
  );
endinterface

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU with register-file write-back; iterative shift-add MUL when EXEC_MUL_EN is defined.
// Latency: ALU ops 1 cycle (one write per cycle back-to-back); MUL N+1 cycles from accept to write-back.
// Backpressure: in_ready drops while a multiply runs; requests are not queued, so upstream holds in_valid.
module exec_unit #(
  parameter int N   = 32,
  parameter int SHW = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  exec_unit_if.slave  io
);
  localparam logic [2:0] NO_WR  = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd7;

  logic [N-1:0] result;

  always_comb begin
    result = '0;
    case (io.op)
      3'd0:    result = io.a + io.b;
      3'd1:    result = io.a - io.b;
      3'd2:    result = io.a & io.b;
      3'd3:    result = io.a | io.b;
      3'd4:    result = io.a ^ io.b;
      3'd5:    result = io.a << io.b[SHW-1:0];
      3'd6:    result = io.a >> io.b[SHW-1:0];
      default: result = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t         state;
  logic [N-1:0]   acc;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic [SHW-1:0] cnt;
  logic [1:0]     dst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      io.wb_sel  <= NO_WR;
      io.wb_data <= '0;
      io.busy    <= 1'b0;
      io.in_ready <= 1'b1;
      acc        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      cnt        <= '0;
      dst_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          io.wb_sel <= NO_WR;
          if (io.in_valid) begin
            if (io.op == OP_MUL) begin
              a_sh        <= io.a;
              b_sh        <= io.b;
              dst_q       <= io.dst;
              acc         <= '0;
              cnt         <= '0;
              io.busy     <= 1'b1;
              io.in_ready <= 1'b0;
              state       <= MUL;
            end else begin
              io.wb_sel  <= {1'b0, io.dst};
              io.wb_data <= result;
            end
          end
        end
        MUL: begin
          // Only the low N bits of the product are kept, so acc never needs to grow.
          if (b_sh[0]) acc <= acc + a_sh;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == SHW'(N - 1)) state <= DONE;
        end
        DONE: begin
          io.wb_sel   <= {1'b0, dst_q};
          io.wb_data  <= acc;
          io.busy     <= 1'b0;
          io.in_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign io.in_ready = 1'b1;
  assign io.busy     = 1'b0;

  // Op 7 still completes in one cycle but leaves the register file untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.wb_sel  <= NO_WR;
      io.wb_data <= '0;
    end else begin
      io.wb_sel <= NO_WR;
      if (io.in_valid && io.op != OP_MUL) begin
        io.wb_sel  <= {1'b0, io.dst};
        io.wb_data <= result;
      end
    end
  end
`endif
endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: stimulus pushes expected write-backs, a negedge monitor pops and compares.
module tb_exec_unit;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exec_unit_if #(.N(N)) io();
  exec_unit #(.N(N), .SHW(5)) dut (.clk(clk), .rst_n(rst_n), .io(io));

  typedef struct packed {
    logic [2:0]   sel;
    logic [N-1:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  passes = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  function automatic wb_t mk(input logic [2:0] sel, input logic [N-1:0] data);
    wb_t w;
    w.sel  = sel;
    w.data = data;
    return w;
  endfunction

  // Monitor: every write-back must match the oldest outstanding expectation.
  initial begin : monitor
    wb_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && io.wb_sel !== 3'd4) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_wb: got sel=%0d data=%h, required no write", io.wb_sel, io.wb_data);
        end else begin
          e = exp_q.pop_front();
          check("wb_sel", N'(io.wb_sel), N'(e.sel));
          check("wb_data", io.wb_data, e.data);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [1:0] dst,
                       input logic [N-1:0] a, input logic [N-1:0] b);
    io.in_valid = 1'b1;
    io.op  = op;
    io.dst = dst;
    io.a   = a;
    io.b   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [2:0] op, input logic [1:0] dst,
                     input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] expv);
    exp_q.push_back(mk({1'b0, dst}, expv));
    issue(op, dst, a, b);
  endtask

  task automatic idle();
    io.in_valid = 1'b0;
    io.op  = 'x;
    io.dst = 'x;
    io.a   = 'x;
    io.b   = 'x;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    check("drain_pending", N'(exp_q.size()), '0);
  endtask

  initial begin : stim
    io.in_valid = 1'b0;
    io.op  = '0;
    io.dst = '0;
    io.a   = '0;
    io.b   = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wb_sel", N'(io.wb_sel), N'(3'd4));
    check("rst_wb_data", io.wb_data, '0);
    check("rst_busy", N'(io.busy), N'(1'b0));
    check("rst_in_ready", N'(io.in_ready), N'(1'b1));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU ops with wrap and shift-amount truncation
    alu(3'd0, 2'd2, 32'hffff_ffff, 32'h1, 32'h0);
    idle();
    alu(3'd1, 2'd1, 32'h0, 32'h1, 32'hffff_ffff);
    idle();
    alu(3'd5, 2'd0, 32'h1, 32'd33, 32'h2);
    alu(3'd6, 2'd3, 32'h8000_0000, 32'd31, 32'h1);
    idle();

    // Back-to-back XOR, OR, AND
    alu(3'd4, 2'd1, 32'h0000_f0f0, 32'h0000_ff00, 32'h0000_0ff0);
    alu(3'd3, 2'd2, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
    alu(3'd2, 2'd3, 32'hffff_0000, 32'h0ff0_0ff0, 32'h0ff0_0000);
    idle();
    @(negedge clk);
    check("b2b_after_sel", N'(io.wb_sel), N'(3'd4));
    @(posedge clk);
    #1;
    alu(3'd0, 2'd0, 32'd5, 32'd7, 32'd12);
    idle();
    drain(10);

`ifdef EXEC_MUL_EN
    begin
      int hold;
      hold = 0;
      // 7*6 while an ADD waits on in_valid; the ADD must follow the MUL write-back.
      exp_q.push_back(mk(3'd3, 32'd42));
      issue(3'd7, 2'd3, 32'd7, 32'd6);
      exp_q.push_back(mk(3'd0, 32'd3));
      io.in_valid = 1'b1;
      io.op  = 3'd0;
      io.dst = 2'd0;
      io.a   = 32'd1;
      io.b   = 32'd2;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (io.wb_sel !== 3'd4) break;
        if (io.busy === 1'b1 && io.in_ready === 1'b0) hold++;
      end
      check("mul_busy_cycles", N'(hold), N'(N + 1));
      @(posedge clk);
      #1;
      idle();
      drain(10);

      exp_q.push_back(mk(3'd1, 32'h0));
      issue(3'd7, 2'd1, 32'h0001_0000, 32'h0001_0000);
      idle();
      drain(60);

      // Abort a multiply with reset partway through.
      issue(3'd7, 2'd2, 32'd3, 32'd3);
      idle();
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy", N'(io.busy), N'(1'b0));
      check("abort_in_ready", N'(io.in_ready), N'(1'b1));
      check("abort_wb_sel", N'(io.wb_sel), N'(3'd4));
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (N + 5) @(negedge clk);
      check("abort_idle_busy", N'(io.busy), N'(1'b0));
      check("abort_idle_ready", N'(io.in_ready), N'(1'b1));
    end
`else
    issue(3'd7, 2'd2, 32'd5, 32'd6);
    @(negedge clk);
    check("op7_in_ready", N'(io.in_ready), N'(1'b1));
    check("op7_busy", N'(io.busy), N'(1'b0));
    check("op7_wb_sel", N'(io.wb_sel), N'(3'd4));
    idle();
    alu(3'd1, 2'd3, 32'd10, 32'd3, 32'd7);
    idle();
    drain(10);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
